seq_detector: RTL

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_detector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_detector
//  Brief    : Serial pattern detector with gap-tolerant sampling, optional
//             overlapping matches, a registered one-cycle match pulse and a
//             saturating match counter.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector #(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b101,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CW      = 8
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          en,
    input  logic          clr,
    input  logic          inp,
    output logic          outp,
    output logic [CW-1:0] match_count
);

    localparam int           FW        = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_ZERO = '0;
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    // Occupancy of the history register; the exact bit count lives in fill_q
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

    fill_state_t     state_q, state_d;
    logic [N-1:0]    hist_q,  hist_d;
    logic [FW-1:0]   fill_q,  fill_d;
    logic            outp_q,  outp_d;
    logic [CW-1:0]   count_q, count_d;

    logic [N-1:0]    hist_shift;
    logic [FW-1:0]   fill_adv;
    logic            fill_bad;
    logic            match;

    // Next-state computation: clear, illegal-encoding recovery, then sampling
    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        state_d    = state_q;
        outp_d     = 1'b0;
        count_d    = count_q;
        hist_shift = {hist_q[N-2:0], inp};
        fill_bad   = (fill_q > FILL_FULL);
        fill_adv   = FILL_ONE;
        match      = 1'b0;

        case (state_q)
            EMPTY:   fill_adv = FILL_ONE;
            PARTIAL: fill_adv = fill_q + FILL_ONE;
            FULL:    fill_adv = FILL_FULL;
            default: fill_bad = 1'b1;
        endcase

        // Match is judged on the post-update history and fill level
        match = (hist_shift == PATTERN) && (fill_adv == FILL_FULL);

        if (clr) begin
            fill_d  = FILL_ZERO;
            state_d = EMPTY;
            count_d = '0;
        end else if (fill_bad) begin
            fill_d  = FILL_ZERO;
            state_d = EMPTY;
        end else if (en) begin
            hist_d = hist_shift;
            fill_d = fill_adv;
            if (match) begin
                outp_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CW'(1);
                end
                // Non-overlapping mode: every bit of a match is consumed
                if (!OVERLAP) begin
                    fill_d = FILL_ZERO;
                end
            end
            if (fill_d == FILL_ZERO) begin
                state_d = EMPTY;
            end else if (fill_d == FILL_FULL) begin
                state_d = FULL;
            end else begin
                state_d = PARTIAL;
            end
        end
    end

    // State, history, pulse and counter registers with asynchronous reset
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= FILL_ZERO;
            outp_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            outp_q  <= outp_d;
            count_q <= count_d;
        end
    end

    assign outp        = outp_q;
    assign match_count = count_q;

endmodule
`default_nettype wire
